// File: rtl/an_serial_encoder.sv
// ---------------------------------------------------------------------------
// an_serial_encoder
//
// Upstream stage of the AN-code datapath. A DATA_W-bit data word N is
// accepted over a valid/ready handshake. The block then forms the codeword
// W = A*N with a bit-serial shift-add multiplier, one multiplier bit per
// cycle. Up to two arithmetic-weight errors (+/-2^pos) can be added to W so
// that the decoder downstream can be exercised in fault-injection runs.
// The golden N is forwarded next to W so a checker can compare it with the
// decoder output.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input word valid
//   in_ready   block can accept a word (high only in IDLE)
//   in_data    data word N
//   inj_en     per-error enable, bit k enables error k
//   inj_sign   per-error sign, 1 = -2^pos, 0 = +2^pos
//   inj_pos0   bit position of error 0
//   inj_pos1   bit position of error 1
//   out_valid  codeword valid
//   out_ready  downstream accepts the codeword
//   out_code   W = A*N + e0 + e1, modulo 2^CODE_W
//   out_data   golden copy of N
//   out_ovf    unwrapped W fell outside [0, 2^CODE_W-1]
//   busy       state is not IDLE
// ---------------------------------------------------------------------------
module an_serial_encoder #(
  parameter int A      = 665,
  parameter int DATA_W = 4,
  parameter int CODE_W = 14,
  parameter int POS_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        inj_en,
  input  logic [1:0]        inj_sign,
  input  logic [POS_W-1:0]  inj_pos0,
  input  logic [POS_W-1:0]  inj_pos1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ovf,
  output logic              busy
);

  // The counter only has to reach DATA_W-1; keep it at least one bit wide.
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  // Two guard bits above the codeword: one for the carry out of the top
  // bit, one as the sign bit, so S = acc + e0 + e1 never wraps.
  localparam int SUM_W = CODE_W + 2;

  localparam logic [CODE_W-1:0] A_CODE   = CODE_W'(A);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIN  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  logic [CNT_W-1:0]  count;
  logic [CODE_W-1:0] acc;

  // Word and injection controls, captured together at acceptance.
  logic [DATA_W-1:0] n_reg;
  logic [1:0]        en_reg;
  logic [1:0]        sign_reg;
  logic [POS_W-1:0]  pos0_reg;
  logic [POS_W-1:0]  pos1_reg;

  logic [CODE_W-1:0] code_reg;
  logic [DATA_W-1:0] data_reg;
  logic              ovf_reg;

  logic              accept;
  logic              last_step;

  logic signed [SUM_W-1:0] err0;
  logic signed [SUM_W-1:0] err1;
  logic signed [SUM_W-1:0] sum;

  // One error term. Positions at or beyond CODE_W are dropped silently so
  // they can never create an overflow on their own.
  function automatic logic signed [SUM_W-1:0] err_term(
    input logic             en,
    input logic             neg,
    input logic [POS_W-1:0] pos
  );
    logic signed [SUM_W-1:0] mag;
    mag = '0;
    if (en && (int'(pos) < CODE_W)) begin
      mag = SUM_W'(1) << pos;
    end
    if (neg) begin
      mag = -mag;
    end
    return mag;
  endfunction

  assign accept    = in_valid && (state == IDLE);
  assign last_step = (count == CNT_LAST);

  assign err0 = err_term(en_reg[0], sign_reg[0], pos0_reg);
  assign err1 = err_term(en_reg[1], sign_reg[1], pos1_reg);
  assign sum  = $signed({2'b00, acc}) + err0 + err1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: IDLE -> MUL (DATA_W cycles) -> FIN -> OUT -> IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (in_valid)  next_state = MUL;
      MUL:  if (last_step) next_state = FIN;
      FIN:                 next_state = OUT;
      OUT:  if (out_ready) next_state = IDLE;
      default:             next_state = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state. out_valid is high
  // exactly in OUT, which is entered on the same edge that loads the
  // result registers, so valid and data always appear together.
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      OUT:     out_valid = 1'b1;
      default: ;
    endcase
  end

  // Capture of the word and injection controls at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_reg    <= '0;
      en_reg   <= '0;
      sign_reg <= '0;
      pos0_reg <= '0;
      pos1_reg <= '0;
    end else if (accept) begin
      n_reg    <= in_data;
      en_reg   <= inj_en;
      sign_reg <= inj_sign;
      pos0_reg <= inj_pos0;
      pos1_reg <= inj_pos1;
    end
  end

  // Shift-add multiplier: one bit of N per MUL cycle, least significant
  // first. The product fits in CODE_W bits by construction of CODE_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      count <= '0;
    end else if (accept) begin
      acc   <= '0;
      count <= '0;
    end else if (state == MUL) begin
      if (n_reg[count]) begin
        acc <= acc + (A_CODE << count);
      end
      count <= count + CNT_W'(1);
    end
  end

  // Result registers, loaded once in FIN and held through OUT. The sum is
  // outside [0, 2^CODE_W-1] exactly when either guard bit is set: the sign
  // bit for a negative sum, the carry bit for one that is too large.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_reg <= '0;
      data_reg <= '0;
      ovf_reg  <= 1'b0;
    end else if (state == FIN) begin
      code_reg <= sum[CODE_W-1:0];
      data_reg <= n_reg;
      ovf_reg  <= sum[SUM_W-1] | sum[CODE_W];
    end
  end

  assign out_code = code_reg;
  assign out_data = data_reg;
  assign out_ovf  = ovf_reg;

endmodule

// File: tb/tb_an_serial_encoder.sv
// ---------------------------------------------------------------------------
// tb_an_serial_encoder
//
// Directed bench for an_serial_encoder with default parameters
// (A = 665, DATA_W = 4, CODE_W = 14, POS_W = 4). Inputs change on the
// falling edge and outputs are sampled on the falling edge, half a cycle
// away from the rising edge the design uses.
// ---------------------------------------------------------------------------
module tb_an_serial_encoder;

  localparam int DATA_W = 4;
  localparam int CODE_W = 14;
  localparam int POS_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        inj_en;
  logic [1:0]        inj_sign;
  logic [POS_W-1:0]  inj_pos0;
  logic [POS_W-1:0]  inj_pos1;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] out_code;
  logic [DATA_W-1:0] out_data;
  logic              out_ovf;
  logic              busy;

  int n_compared   = 0;
  int n_mismatched = 0;

  an_serial_encoder #(
    .A      (665),
    .DATA_W (DATA_W),
    .CODE_W (CODE_W),
    .POS_W  (POS_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .inj_en    (inj_en),
    .inj_sign  (inj_sign),
    .inj_pos0  (inj_pos0),
    .inj_pos1  (inj_pos1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Present one word at a falling edge and hold it across one rising edge.
  // Returns at the falling edge right after the accepting edge.
  task automatic applyStimulus(input logic [DATA_W-1:0] data, input logic [1:0] en,
                               input logic [1:0] sign, input logic [POS_W-1:0] p0,
                               input logic [POS_W-1:0] p1);
    checkOutput("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = data;
    inj_en   = en;
    inj_sign = sign;
    inj_pos0 = p0;
    inj_pos1 = p1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called at the falling edge after the accepting edge. out_valid must
  // rise after the fifth rising edge counted from acceptance.
  task automatic waitForValid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_latency"}, 32'(n), 32'd5);
  endtask

  // Compare the presented result, then complete the transfer.
  task automatic checkWord(input string tag, input int code, input int data,
                           input logic ovf);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_code"},  32'(out_code),  32'(code));
    checkOutput({tag, "_data"},  32'(out_data),  32'(data));
    checkOutput({tag, "_ovf"},   32'(out_ovf),   32'(ovf));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_ready_back"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    inj_en    = '0;
    inj_sign  = '0;
    inj_pos0  = '0;
    inj_pos1  = '0;
    out_ready = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
    checkOutput("rst_busy",      32'(busy),      32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_code",  32'(out_code),  32'd0);
    checkOutput("rst_out_data",  32'(out_data),  32'd0);
    checkOutput("rst_out_ovf",   32'(out_ovf),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Plain encoding of N = 5, with MUL-phase status checks.
    applyStimulus(4'd5, 2'b00, 2'b00, 4'd0, 4'd0);
    checkOutput("mul_in_ready", 32'(in_ready), 32'd0);
    checkOutput("mul_busy",     32'(busy),     32'd1);
    waitForValid("n5");
    checkWord("n5", 3325, 5, 1'b0);

    // Every data word without injection: W = 665*N.
    for (int n = 0; n < 16; n++) begin
      applyStimulus(4'(n), 2'b00, 2'b00, 4'd0, 4'd0);
      waitForValid($sformatf("sweep%0d", n));
      checkWord($sformatf("sweep%0d", n), 665 * n, n, 1'b0);
    end

    // Two errors, opposite signs at different positions.
    applyStimulus(4'd5, 2'b11, 2'b01, 4'd0, 4'd3);
    waitForValid("inj_m1_p8");
    checkWord("inj_m1_p8", 3332, 5, 1'b0);
    applyStimulus(4'd5, 2'b11, 2'b10, 4'd0, 4'd3);
    waitForValid("inj_p1_m8");
    checkWord("inj_p1_m8", 3318, 5, 1'b0);

    // Overflow above the range: 9975 + 8192 = 18167 wraps to 1783.
    applyStimulus(4'd15, 2'b01, 2'b00, 4'd13, 4'd0);
    waitForValid("ovf_high");
    checkWord("ovf_high", 1783, 15, 1'b1);

    // Overflow below zero: 0 - 1 wraps to 16383.
    applyStimulus(4'd0, 2'b01, 2'b01, 4'd0, 4'd0);
    waitForValid("ovf_low");
    checkWord("ovf_low", 16383, 0, 1'b1);

    // Out-of-range position is ignored entirely.
    applyStimulus(4'd1, 2'b01, 2'b00, 4'd14, 4'd0);
    waitForValid("pos_oob");
    checkWord("pos_oob", 665, 1, 1'b0);

    // Same position, opposite signs: the errors cancel.
    applyStimulus(4'd1, 2'b11, 2'b01, 4'd2, 4'd2);
    waitForValid("cancel");
    checkWord("cancel", 665, 1, 1'b0);

    // Same position, same sign: 665 + 4 + 4 = 673.
    applyStimulus(4'd1, 2'b11, 2'b00, 4'd2, 4'd2);
    waitForValid("double");
    checkWord("double", 673, 1, 1'b0);

    // Backpressure: out_ready held low for 10 cycles while the next word
    // (N = 7) already waits on the input.
    applyStimulus(4'd3, 2'b00, 2'b00, 4'd0, 4'd0);
    in_valid = 1'b1;
    in_data  = 4'd7;
    inj_en   = 2'b00;
    waitForValid("stall");
    for (int i = 0; i < 10; i++) begin
      checkOutput("stall_valid",    32'(out_valid), 32'd1);
      checkOutput("stall_code",     32'(out_code),  32'd1995);
      checkOutput("stall_data",     32'(out_data),  32'd3);
      checkOutput("stall_in_ready", 32'(in_ready),  32'd0);
      checkOutput("stall_busy",     32'(busy),      32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("release_valid",    32'(out_valid), 32'd0);
    checkOutput("release_in_ready", 32'(in_ready),  32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("next_in_ready", 32'(in_ready), 32'd0);
    checkOutput("next_busy",     32'(busy),     32'd1);
    waitForValid("next");
    checkWord("next", 4655, 7, 1'b0);

    // out_ready already high when out_valid rises.
    out_ready = 1'b1;
    applyStimulus(4'd2, 2'b00, 2'b00, 4'd0, 4'd0);
    out_ready = 1'b1;
    waitForValid("early_ready");
    checkOutput("early_ready_code", 32'(out_code), 32'd1330);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("early_ready_drop", 32'(out_valid), 32'd0);

    // Reset in MUL with counter = 2 aborts the word at once.
    applyStimulus(4'd9, 2'b01, 2'b00, 4'd1, 4'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_in_ready",  32'(in_ready),  32'd1);
    checkOutput("abort_busy",      32'(busy),      32'd0);
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_out_code",  32'(out_code),  32'd0);
    checkOutput("abort_out_data",  32'(out_data),  32'd0);
    checkOutput("abort_out_ovf",   32'(out_ovf),   32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("abort_no_output", 32'(out_valid), 32'd0);
    checkOutput("abort_idle",      32'(busy),      32'd0);
    applyStimulus(4'd6, 2'b00, 2'b00, 4'd0, 4'd0);
    waitForValid("after_abort");
    checkWord("after_abort", 3990, 6, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
